// File: rtl/alu_seq.sv
// Multi-cycle W-bit ALU with start/done handshake and registered result flags.
// Define ALU_MUL_EN to enable the shift-add multiplier on opcode 1110.
module alu_seq #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         pari,
  output logic         zero
);

  localparam int unsigned SHW = $clog2(W);
  localparam int unsigned CW  = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic           shr_q;
  logic [W-1:0]   sh_q;
  logic [CW-1:0]  cnt_q;

  logic [SHW-1:0] shamt;
  logic [W:0]     sum;
  logic [W-1:0]   one_r;
  logic           one_c;
  logic           multi;
  logic [W-1:0]   sh_nx;
  logic           sh_out;
  logic [W-1:0]   fin_r;
  logic           fin_c;

`ifdef ALU_MUL_EN
  logic           mul_q;
  logic [W-1:0]   mca_q;
  logic [2*W-1:0] prod_q;
  logic [W:0]     mul_hi;
  logic [2*W-1:0] prod_nx;
  logic           is_mul;
`endif

  // Decode for single-cycle ops; multi marks ops that need the RUN state.
  always_comb begin
    shamt = inB[SHW-1:0];
    sum   = '0;
    one_r = '0;
    one_c = 1'b0;
    multi = 1'b0;
`ifdef ALU_MUL_EN
    is_mul = 1'b0;
`endif
    case (alu_cmd)
      4'b0000: begin
        sum   = {1'b0, inA} + {1'b0, inB} + (W+1)'(sc_i);
        one_r = sum[W-1:0];
        one_c = sum[W];
      end
      4'b0001: begin
        sum   = {1'b0, inA} - {1'b0, inB};
        one_r = sum[W-1:0];
        one_c = sum[W];
      end
      4'b0010: one_r = inB;
      4'b0011: one_r = inA & inB;
      4'b0100: one_r = inA ^ inB;
      4'b0101: one_r = inA | inB;
      4'b1010, 4'b1011: begin
        if (shamt == '0) one_r = inA;
        else             multi = 1'b1;
      end
      4'b1100: one_r = {{(W-1){1'b0}}, inA != inB};
      4'b1101: one_r = {{(W-1){1'b0}}, inA < inB};
`ifdef ALU_MUL_EN
      4'b1110: begin
        multi  = 1'b1;
        is_mul = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    sh_nx  = shr_q ? (sh_q >> 1) : (sh_q << 1);
    sh_out = shr_q ? sh_q[0] : sh_q[W-1];
    fin_r  = sh_nx;
    fin_c  = sh_out;
`ifdef ALU_MUL_EN
    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole product right by one.
    mul_hi  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mca_q} : '0);
    prod_nx = {mul_hi, prod_q[W-1:1]};
    if (mul_q) begin
      fin_r = prod_nx[W-1:0];
      fin_c = |prod_nx[2*W-1:W];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      shr_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rslt    <= '0;
      sc_o    <= 1'b0;
      pari    <= 1'b0;
      zero    <= 1'b0;
`ifdef ALU_MUL_EN
      mul_q   <= 1'b0;
      mca_q   <= '0;
      prod_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StRun: begin
          sh_q  <= sh_nx;
          cnt_q <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
          prod_q <= prod_nx;
`endif
          if (cnt_q == CW'(1)) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            rslt    <= fin_r;
            sc_o    <= fin_c;
            pari    <= ^fin_r;
            zero    <= (fin_r == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            if (multi) begin
              state_q <= StRun;
              busy    <= 1'b1;
              shr_q   <= alu_cmd[0];
              sh_q    <= inA;
`ifdef ALU_MUL_EN
              mul_q   <= is_mul;
              mca_q   <= inA;
              prod_q  <= {{W{1'b0}}, inB};
              cnt_q   <= is_mul ? CW'(W) : CW'(shamt);
`else
              cnt_q   <= CW'(shamt);
`endif
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
              rslt    <= one_r;
              sc_o    <= one_c;
              pari    <= ^one_r;
              zero    <= (one_r == '0);
            end
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed table, corner sequences, random vs model.
module tb_alu_seq;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [3:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         sc_i;
  logic         busy;
  logic         done;
  logic [W-1:0] rslt;
  logic         sc_o;
  logic         pari;
  logic         zero;

  int n_pass = 0;
  int n_tot  = 0;

  alu_seq #(.W(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .alu_cmd (alu_cmd),
    .inA     (inA),
    .inB     (inB),
    .sc_i    (sc_i),
    .busy    (busy),
    .done    (done),
    .rslt    (rslt),
    .sc_o    (sc_o),
    .pari    (pari),
    .zero    (zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] r;
    logic       f;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference behaviour from the operation table, in plain integer arithmetic.
  function automatic void model(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                input logic c, output logic [7:0] r, output logic f,
                                output int lat);
    int ia = int'(a);
    int ib = int'(b);
    int n  = ib % 8;
    int s;
    r = 8'h00;
    f = 1'b0;
    lat = 1;
    case (cmd)
      4'd0: begin s = ia + ib + int'(c); r = 8'(s % 256); f = (s > 255); end
      4'd1: begin r = 8'((ia - ib + 256) % 256); f = (ia < ib); end
      4'd2: r = b;
      4'd3: r = a & b;
      4'd4: r = a ^ b;
      4'd5: r = a | b;
      4'd10: begin
        r = 8'((ia * (1 << n)) % 256);
        f = (n != 0) && (((ia >> (8 - n)) % 2) == 1);
        lat = 1 + n;
      end
      4'd11: begin
        r = 8'(ia >> n);
        f = (n != 0) && (((ia >> (n - 1)) % 2) == 1);
        lat = 1 + n;
      end
      4'd12: r = (ia != ib) ? 8'd1 : 8'd0;
      4'd13: r = (ia < ib) ? 8'd1 : 8'd0;
`ifdef ALU_MUL_EN
      4'd14: begin s = ia * ib; r = 8'(s % 256); f = (s > 255); lat = 1 + W; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op at the next edge, then follow it to done and check everything.
  task automatic issue(input string nm, input logic [3:0] cmd, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic [7:0] er,
                       input logic ef, input int elat);
    logic [7:0] prev_r = rslt;
    logic       prev_f = sc_o;
    int         k = 1;
    int         busy_cnt = 0;
    int         stable = 1;
    start = 1'b1; alu_cmd = cmd; inA = a; inB = b; sc_i = c;
    tick();
    start = 1'b0;
    alu_cmd = 4'($urandom); inA = 8'($urandom); inB = 8'($urandom); sc_i = 1'($urandom);
    while (!done && k < elat + 4) begin
      if (busy) busy_cnt++;
      if (rslt !== prev_r || sc_o !== prev_f) stable = 0;
      tick();
      k++;
    end
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " latency"}, k, elat);
    chk({nm, " busy cycles"}, busy_cnt, elat - 1);
    chk({nm, " held"}, stable, 1);
    chk({nm, " rslt"}, int'(rslt), int'(er));
    chk({nm, " sc_o"}, int'(sc_o), int'(ef));
    chk({nm, " pari"}, int'(pari), int'(^er));
    chk({nm, " zero"}, int'(zero), (er == 8'h00) ? 1 : 0);
    chk({nm, " busy at done"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] mr;
    logic       mf;
    int         ml;
    int         k;
    int         seen;
    logic [3:0] rc;
    logic [7:0] ra, rb;
    logic       rcin;

    vecs[0]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1};
    vecs[1]  = '{4'hC, 8'h02, 8'h02, 1'b0, 8'h00, 1'b0, 1};
    vecs[2]  = '{4'hC, 8'h00, 8'h02, 1'b0, 8'h01, 1'b0, 1};
    vecs[3]  = '{4'hA, 8'h10, 8'h03, 1'b0, 8'h80, 1'b0, 4};
    vecs[4]  = '{4'hB, 8'h10, 8'h05, 1'b0, 8'h00, 1'b1, 6};
    vecs[5]  = '{4'hA, 8'h81, 8'h08, 1'b0, 8'h81, 1'b0, 1};
    vecs[6]  = '{4'h1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1};
    vecs[7]  = '{4'h0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1};
`ifdef ALU_MUL_EN
    vecs[8]  = '{4'hE, 8'h10, 8'h11, 1'b0, 8'h10, 1'b1, 9};
`else
    vecs[8]  = '{4'hE, 8'h10, 8'h11, 1'b0, 8'h00, 1'b0, 1};
`endif
    vecs[9]  = '{4'h6, 8'h55, 8'h33, 1'b1, 8'h00, 1'b0, 1};
    vecs[10] = '{4'hD, 8'h01, 8'h02, 1'b0, 8'h01, 1'b0, 1};
    vecs[11] = '{4'h4, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1};

    Reset = 1'b1; start = 1'b0; alu_cmd = 4'h0; inA = 8'h00; inB = 8'h00; sc_i = 1'b0;
    tick();
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset rslt", int'(rslt), 0);
    chk("reset sc_o", int'(sc_o), 0);
    chk("reset pari", int'(pari), 0);
    chk("reset zero", int'(zero), 0);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].c,
            vecs[i].r, vecs[i].f, vecs[i].lat);
      if (i % 3 == 0) tick();
    end

    // start held high through an SHL by 7: only the first is taken, next lands in DONE.
    start = 1'b1; alu_cmd = 4'hA; inA = 8'h01; inB = 8'h07; sc_i = 1'b0;
    tick();
    alu_cmd = 4'h0; inA = 8'h01; inB = 8'h02;
    k = 1;
    seen = 0;
    while (!done && k < 20) begin
      if (!busy) seen++;
      tick();
      k++;
    end
    chk("hammer latency", k, 8);
    chk("hammer not busy early", seen, 0);
    chk("hammer rslt", int'(rslt), 8'h80);
    chk("hammer sc_o", int'(sc_o), 0);
    tick();
    start = 1'b0;
    chk("b2b done", int'(done), 1);
    chk("b2b rslt", int'(rslt), 3);
    chk("b2b busy", int'(busy), 0);

    // Reset wins over start in the same cycle.
    start = 1'b1; Reset = 1'b1; alu_cmd = 4'h0; inA = 8'hFF; inB = 8'hFF;
    tick();
    start = 1'b0; Reset = 1'b0;
    chk("rst-vs-start done", int'(done), 0);
    chk("rst-vs-start rslt", int'(rslt), 0);

    // Reset mid-shift aborts with no done pulse.
    issue("pre-abort add", 4'h0, 8'h40, 8'h01, 1'b0, 8'h41, 1'b0, 1);
    start = 1'b1; alu_cmd = 4'hA; inA = 8'h03; inB = 8'h06;
    tick();
    start = 1'b0;
    tick();
    chk("mid busy", int'(busy), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort rslt", int'(rslt), 0);
    chk("abort sc_o", int'(sc_o), 0);
    chk("abort pari", int'(pari), 0);
    chk("abort zero", int'(zero), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) seen++;
      tick();
    end
    chk("abort no done", seen, 0);

    // Random ops against the reference model, with occasional idle gaps.
    for (int i = 0; i < 80; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rcin = 1'($urandom);
      model(rc, ra, rb, rcin, mr, mf, ml);
      issue($sformatf("rnd%0d cmd%0h a%0h b%0h c%0d", i, rc, ra, rb, rcin),
            rc, ra, rb, rcin, mr, mf, ml);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
